// File: rtl/sdram_pkg.sv
// Shared SDRAM geometry, write-line sizing, address field positions and
// issue-FSM encodings for the burst-write feeder.
package sdram_pkg;

  localparam int unsigned SDRAM_ROW_W  = 13;
  localparam int unsigned SDRAM_COL_W  = 10;
  localparam int unsigned SDRAM_BANK_W = 2;
  localparam int unsigned SDRAM_WORD_W = 16;
  localparam int unsigned BURST_LEN    = 8;
  localparam int unsigned LINE_W       = SDRAM_WORD_W * BURST_LEN;
  localparam int unsigned ADDR_W       = SDRAM_BANK_W + SDRAM_ROW_W + SDRAM_COL_W;

  localparam int unsigned COL_LSB  = 0;
  localparam int unsigned COL_MSB  = COL_LSB + SDRAM_COL_W - 1;
  localparam int unsigned ROW_LSB  = COL_MSB + 1;
  localparam int unsigned ROW_MSB  = ROW_LSB + SDRAM_ROW_W - 1;
  localparam int unsigned BANK_LSB = ROW_MSB + 1;
  localparam int unsigned BANK_MSB = BANK_LSB + SDRAM_BANK_W - 1;

  // Lines are burst-aligned, so the beat-select column bits are always cleared.
  localparam logic [SDRAM_COL_W-1:0] COL_ALIGN_MASK = ~SDRAM_COL_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [SDRAM_BANK_W-1:0] bank;
    logic [SDRAM_ROW_W-1:0]  row;
    logic [SDRAM_COL_W-1:0]  col;
  } sdram_addr_t;

  function automatic sdram_addr_t split_addr(input logic [ADDR_W-1:0] a);
    sdram_addr_t r;
    r.bank = a[BANK_MSB:BANK_LSB];
    r.row  = a[ROW_MSB:ROW_LSB];
    r.col  = a[COL_MSB:COL_LSB] & COL_ALIGN_MASK;
    return r;
  endfunction

endpackage

// File: rtl/sdram_line_buf.sv
// Ping-pong line store: shifts user words into the fill slot, tracks per-slot
// full flags and presents the drain slot to the issue logic.
module sdram_line_buf
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LINES     = 2
) (
  input  logic                           iclk,
  input  logic                           ctr_reset,
  input  logic                           push,
  input  logic                           push_first,
  input  logic [DATA_W-1:0]              push_data,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic                           pop,
  output logic [$clog2(BURST_LEN)-1:0]   beat_cnt,
  output logic                           has_free,
  output logic                           head_full_c,
  output logic [DATA_W*BURST_LEN-1:0]    head_data_c,
  output logic [ADDR_W-1:0]              head_addr_c
);

  localparam int unsigned LINE_BITS = DATA_W * BURST_LEN;
  localparam int unsigned CNT_W     = $clog2(BURST_LEN);
  localparam int unsigned PTR_W     = $clog2(LINES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [LINE_BITS-1:0] line_q [LINES];
  logic [ADDR_W-1:0]    addr_q [LINES];
  logic [LINES-1:0]     full_q;
  logic [LINES-1:0]     full_d;
  logic [PTR_W-1:0]     fill_ptr;
  logic [PTR_W-1:0]     drain_ptr;
  logic                 line_done_c;

  assign line_done_c = push & ~push_first & (beat_cnt == LAST_BEAT);

  // Each slot's flag is updated on its own, so a fill and a drain of different slots can share a cycle.
  always_comb begin
    full_d = full_q;
    if (pop)         full_d[drain_ptr] = 1'b0;
    if (line_done_c) full_d[fill_ptr]  = 1'b1;
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      line_q    <= '{default: '0};
      addr_q    <= '{default: '0};
      full_q    <= '0;
      fill_ptr  <= '0;
      drain_ptr <= '0;
      beat_cnt  <= '0;
      has_free  <= 1'b0;
    end else begin
      full_q   <= full_d;
      has_free <= ~&full_d;
      if (pop) drain_ptr <= PTR_W'(drain_ptr + 1'b1);
      if (push) begin
        if (push_first) begin
          // A new first word always restarts the fill slot, dropping any partial line.
          line_q[fill_ptr] <= LINE_BITS'(push_data);
          addr_q[fill_ptr] <= push_addr;
          beat_cnt         <= CNT_W'(1);
        end else begin
          line_q[fill_ptr] <= {line_q[fill_ptr][LINE_BITS-DATA_W-1:0], push_data};
          if (line_done_c) begin
            beat_cnt <= '0;
            fill_ptr <= PTR_W'(fill_ptr + 1'b1);
          end else begin
            beat_cnt <= CNT_W'(beat_cnt + 1'b1);
          end
        end
      end
    end
  end

  assign head_full_c = full_q[drain_ptr];
  assign head_data_c = line_q[drain_ptr];
  assign head_addr_c = addr_q[drain_ptr];

endmodule

// File: rtl/sdram_write_gather.sv
// Gathers 16-bit user writes into 8-beat lines and hands each completed line
// to the SDRAM burst-write stage with a one-cycle request / finish handshake.
module sdram_write_gather
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LINES     = 2
) (
  input  logic                        iclk,
  input  logic                        ctr_reset,
  input  logic                        iwr_valid,
  output logic                        iwr_ready,
  input  logic                        iwr_first,
  input  logic [ADDR_W-1:0]           iwr_addr,
  input  logic [DATA_W-1:0]           iwr_data,
  input  logic                        igrant,
  output logic                        oreq,
  input  logic                        ifin,
  output logic [SDRAM_ROW_W-1:0]      orow,
  output logic [SDRAM_COL_W-1:0]      ocolumn,
  output logic [SDRAM_BANK_W-1:0]     obank,
  output logic [DATA_W*BURST_LEN-1:0] odata,
  output logic                        obusy,
  output logic                        oerr
);

  localparam int unsigned LINE_BITS = DATA_W * BURST_LEN;
  localparam int unsigned CNT_W     = $clog2(BURST_LEN);

  logic [CNT_W-1:0]     beat_cnt;
  logic                 accept_c;
  logic                 mid_line_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 err_c;
  logic                 head_full_c;
  logic [LINE_BITS-1:0] head_data_c;
  logic [ADDR_W-1:0]    head_addr_c;
  sdram_addr_t          head_fields_c;
  issue_state_e         state;

  assign accept_c   = iwr_valid & iwr_ready;
  assign mid_line_c = (beat_cnt != '0);

  // Words without a leading first are dropped; a first arriving mid-line restarts the line.
  assign push_c = accept_c & (iwr_first | mid_line_c);
  assign err_c  = accept_c & ((iwr_first & mid_line_c) | (~iwr_first & ~mid_line_c));

  // Only a finish seen while waiting releases the head slot.
  assign pop_c = (state == ST_WAIT) & ifin;

  assign head_fields_c = split_addr(head_addr_c);

  sdram_line_buf #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .LINES     (LINES)
  ) u_line_buf (
    .iclk        (iclk),
    .ctr_reset   (ctr_reset),
    .push        (push_c),
    .push_first  (iwr_first),
    .push_data   (iwr_data),
    .push_addr   (iwr_addr),
    .pop         (pop_c),
    .beat_cnt    (beat_cnt),
    .has_free    (iwr_ready),
    .head_full_c (head_full_c),
    .head_data_c (head_data_c),
    .head_addr_c (head_addr_c)
  );

  // Issue FSM; line fields are loaded once on leaving IDLE and held until the finish pulse.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state   <= ST_IDLE;
      oreq    <= 1'b0;
      obusy   <= 1'b0;
      oerr    <= 1'b0;
      orow    <= '0;
      ocolumn <= '0;
      obank   <= '0;
      odata   <= '0;
    end else begin
      oerr <= err_c;
      oreq <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (head_full_c && igrant) begin
            state   <= ST_REQ;
            oreq    <= 1'b1;
            obusy   <= 1'b1;
            orow    <= head_fields_c.row;
            ocolumn <= head_fields_c.col;
            obank   <= head_fields_c.bank;
            odata   <= head_data_c;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ifin) begin
            state <= ST_IDLE;
            obusy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_gather.sv
// Bench for sdram_write_gather: a queue-based line model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sdram_write_gather;

  logic          iclk      = 1'b0;
  logic          ctr_reset = 1'b1;
  logic          iwr_valid = 1'b0;
  logic          iwr_first = 1'b0;
  logic [24:0]   iwr_addr  = '0;
  logic [15:0]   iwr_data  = '0;
  logic          igrant    = 1'b0;
  logic          ifin      = 1'b0;
  logic          iwr_ready;
  logic          oreq;
  logic          obusy;
  logic          oerr;
  logic [12:0]   orow;
  logic [9:0]    ocolumn;
  logic [1:0]    obank;
  logic [127:0]  odata;

  sdram_write_gather dut (
    .iclk      (iclk),
    .ctr_reset (ctr_reset),
    .iwr_valid (iwr_valid),
    .iwr_ready (iwr_ready),
    .iwr_first (iwr_first),
    .iwr_addr  (iwr_addr),
    .iwr_data  (iwr_data),
    .igrant    (igrant),
    .oreq      (oreq),
    .ifin      (ifin),
    .orow      (orow),
    .ocolumn   (ocolumn),
    .obank     (obank),
    .odata     (odata),
    .obusy     (obusy),
    .oerr      (oerr)
  );

  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [24:0]  addr;
    logic [127:0] data;
  } mline_t;

  mline_t      m_lines[$];
  logic [15:0] m_part [8];
  logic [24:0] m_paddr = '0;
  int          m_cnt   = 0;
  mline_t      e_out   = '0;
  logic        e_ready = 1'b0;
  logic        e_oreq  = 1'b0;
  logic        e_busy  = 1'b0;
  logic        e_err   = 1'b0;
  logic        m_acc;
  int          m_nbefore;

  always @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      m_lines.delete();
      m_cnt   = 0;
      e_out   = '0;
      e_ready = 1'b0;
      e_oreq  = 1'b0;
      e_busy  = 1'b0;
      e_err   = 1'b0;
    end else begin
      m_acc     = iwr_valid && e_ready;
      m_nbefore = m_lines.size();
      e_err     = 1'b0;
      if (e_oreq) begin
        e_oreq = 1'b0;
      end else if (e_busy) begin
        if (ifin) begin
          void'(m_lines.pop_front());
          e_busy = 1'b0;
        end
      end else if (m_nbefore > 0 && igrant) begin
        e_out  = m_lines[0];
        e_oreq = 1'b1;
        e_busy = 1'b1;
      end
      if (m_acc) begin
        if (iwr_first) begin
          if (m_cnt != 0) e_err = 1'b1;
          m_paddr   = iwr_addr;
          m_part[0] = iwr_data;
          m_cnt     = 1;
        end else if (m_cnt == 0) begin
          e_err = 1'b1;
        end else begin
          m_part[m_cnt] = iwr_data;
          m_cnt++;
          if (m_cnt == 8) begin
            mline_t nl;
            nl.addr = m_paddr;
            nl.data = '0;
            for (int i = 0; i < 8; i++) nl.data[127-16*i -: 16] = m_part[i];
            m_lines.push_back(nl);
            m_cnt = 0;
          end
        end
      end
      e_ready = (m_lines.size() < 2);
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_oreq = 0;
  int n_stall = 0;

  always @(posedge iclk) begin
    if (iwr_valid && !iwr_ready) n_stall++;
    #3;
    if (oreq === 1'b1) n_oreq++;
    chk("cyc_iwr_ready", 128'(iwr_ready), 128'(e_ready));
    chk("cyc_oreq",      128'(oreq),      128'(e_oreq));
    chk("cyc_obusy",     128'(obusy),     128'(e_busy));
    chk("cyc_oerr",      128'(oerr),      128'(e_err));
    chk("cyc_orow",      128'(orow),      128'(e_out.addr[22:10]));
    chk("cyc_ocolumn",   128'(ocolumn),   128'({e_out.addr[9:3], 3'b000}));
    chk("cyc_obank",     128'(obank),     128'(e_out.addr[24:23]));
    chk("cyc_odata",     odata,           e_out.data);
  end

  // ---------------- write-stage responder ----------------
  int fin_delay = 3;

  initial begin
    logic aborted;
    forever begin
      @(posedge iclk);
      #3;
      if (oreq === 1'b1) begin
        aborted = 1'b0;
        for (int i = 0; i < fin_delay; i++) begin
          @(negedge iclk);
          if (ctr_reset) aborted = 1'b1;
        end
        if (!aborted && !ctr_reset) begin
          ifin = 1'b1;
          @(negedge iclk);
          ifin = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers (start and end just after a negedge) ----------------
  task automatic push_word(input logic first, input logic [24:0] a, input logic [15:0] d);
    int t;
    t = 0;
    iwr_valid = 1'b1;
    iwr_first = first;
    iwr_addr  = a;
    iwr_data  = d;
    while (iwr_ready !== 1'b1 && t < 300) begin
      @(negedge iclk);
      t++;
    end
    if (t >= 300) chk("push_timeout", 128'(iwr_ready), 128'(1));
    @(negedge iclk);
    iwr_valid = 1'b0;
    iwr_first = 1'b0;
  endtask

  task automatic send_line(input logic [24:0] a, input logic [15:0] w0, input logic [15:0] step);
    for (int i = 0; i < 8; i++) push_word(i == 0, a, 16'(w0 + 16'(i) * step));
  endtask

  task automatic wait_oreq(input string nm);
    int t;
    t = 0;
    while (oreq !== 1'b1 && t < 100) begin
      @(negedge iclk);
      t++;
    end
    chk(nm, 128'(oreq), 128'(1));
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((obusy !== 1'b0 || m_lines.size() != 0) && t < 500) begin
      @(negedge iclk);
      t++;
    end
    chk(nm, 128'(obusy), 128'(0));
  endtask

  // ---------------- directed scenarios ----------------
  int oreq_base;
  int stall_base;

  initial begin
    igrant = 1'b1;
    repeat (3) @(negedge iclk);
    chk("rst_iwr_ready", 128'(iwr_ready), 128'(0));
    chk("rst_oreq",      128'(oreq),      128'(0));
    chk("rst_obusy",     128'(obusy),     128'(0));
    chk("rst_oerr",      128'(oerr),      128'(0));
    chk("rst_odata",     odata,           128'(0));
    ctr_reset = 1'b0;
    @(negedge iclk);
    chk("rel_iwr_ready", 128'(iwr_ready), 128'(1));

    // Single line with decoded address
    fin_delay = 20;
    send_line(25'h0A12348, 16'h1111, 16'h1111);
    wait_oreq("t1_oreq");
    chk("t1_orow",    128'(orow),         128'(13'h0848));
    chk("t1_ocolumn", 128'(ocolumn),      128'(10'h348));
    chk("t1_col_lo",  128'(ocolumn[2:0]), 128'(0));
    chk("t1_obank",   128'(obank),        128'(2'd1));
    chk("t1_odata",   odata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    wait_idle("t1_idle");

    // Three lines streamed back to back
    fin_delay  = 15;
    oreq_base  = n_oreq;
    stall_base = n_stall;
    send_line(25'h0000007, 16'h1000, 16'h0001);
    send_line(25'h1555555, 16'h2000, 16'h0001);
    send_line(25'h0C0FFEE, 16'h3000, 16'h0001);
    wait_idle("t2_idle");
    chk("t2_oreq_count", 128'(n_oreq - oreq_base), 128'(3));
    chk("t2_ready_drop", 128'(n_stall > stall_base), 128'(1));

    // Grant gating and column alignment
    fin_delay = 3;
    igrant = 1'b0;
    send_line(25'h1FFFFFF, 16'h4000, 16'h0101);
    for (int i = 0; i < 10; i++) begin
      @(negedge iclk);
      chk("t3_no_oreq", 128'(oreq), 128'(0));
    end
    igrant = 1'b1;
    @(negedge iclk);
    chk("t3_oreq",    128'(oreq),    128'(1));
    chk("t3_orow",    128'(orow),    128'(13'h1FFF));
    chk("t3_ocolumn", 128'(ocolumn), 128'(10'h3F8));
    chk("t3_obank",   128'(obank),   128'(2'd3));
    wait_idle("t3_idle");

    // Broken line: new first at beat 4
    push_word(1'b1, 25'h0123450, 16'hDEA0);
    for (int i = 1; i < 4; i++) push_word(1'b0, 25'h0123450, 16'(16'hDEA0 + 16'(i)));
    push_word(1'b1, 25'h0040010, 16'hA001);
    chk("t4_oerr", 128'(oerr), 128'(1));
    for (int i = 1; i < 8; i++) push_word(1'b0, 25'h0040010, 16'(16'hA001 + 16'(i)));
    wait_oreq("t4_oreq");
    chk("t4_odata", odata, 128'hA001_A002_A003_A004_A005_A006_A007_A008);
    wait_idle("t4_idle");

    // Missing first at count 0
    push_word(1'b0, 25'h0000000, 16'hBAD0);
    chk("t5_oerr",  128'(oerr),      128'(1));
    chk("t5_ready", 128'(iwr_ready), 128'(1));
    send_line(25'h0ABCDE8, 16'h0101, 16'h0101);
    wait_oreq("t5_oreq");
    chk("t5_odata", odata, 128'h0101_0202_0303_0404_0505_0606_0707_0808);
    wait_idle("t5_idle");

    // Reset while waiting for finish
    fin_delay = 30;
    send_line(25'h0777770, 16'h5000, 16'h0001);
    wait_oreq("t6_oreq");
    repeat (3) @(negedge iclk);
    ctr_reset = 1'b1;
    #1;
    chk("t6_rst_oreq",  128'(oreq),  128'(0));
    chk("t6_rst_obusy", 128'(obusy), 128'(0));
    chk("t6_rst_odata", odata,       128'(0));
    chk("t6_rst_orow",  128'(orow),  128'(0));
    chk("t6_rst_ready", 128'(iwr_ready), 128'(0));
    @(negedge iclk);
    @(negedge iclk);
    ctr_reset = 1'b0;
    @(negedge iclk);
    chk("t6_rel_ready", 128'(iwr_ready), 128'(1));
    fin_delay = 4;
    send_line(25'h1000000, 16'h9000, 16'h0001);
    wait_oreq("t6_new_oreq");
    chk("t6_new_obank", 128'(obank), 128'(2'd2));
    chk("t6_new_odata", odata, 128'h9000_9001_9002_9003_9004_9005_9006_9007);
    wait_idle("t6_idle");

    repeat (5) @(negedge iclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
